// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner, sync-read IMEM initiator and skid FIFO toward decode.
// Optional IFU_BUBBLE_CNT_EN adds the PERF_BUBBLES starvation counter.
module instruction_fetch_unit #(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DATA_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST,
    output logic [ADDR_W-1:0]   IMEM_ADDR,
    input  logic [DATA_W-1:0]   IMEM_DATA,
    output logic [DATA_W-1:0]   INSTR,
    output logic [ADDR_W-1:0]   INSTR_PC,
    output logic                INSTR_VALID,
    input  logic                INSTR_READY,
`ifdef IFU_BUBBLE_CNT_EN
    output logic [31:0]         PERF_BUBBLES,
`endif
    input  logic                BRANCH_EN,
    input  logic [ADDR_W-1:0]   BRANCH_TARGET
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              issue_q, issue_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_q   [FIFO_DEPTH];

    logic              valid;
    logic              pop;
    logic              push;
    logic              issue_ok;
    logic [CW:0]       occupancy;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid = (count_q != '0);
    assign pop   = valid & INSTR_READY;
    assign push  = issue_q & ~BRANCH_EN;

    // Slots already promised: buffered words plus the read in flight, minus the one leaving.
    assign occupancy = ({1'b0, count_q} + (CW+1)'(issue_q)) - (CW+1)'(pop);
    assign issue_ok  = ~BRANCH_EN & (occupancy < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        issue_d    = issue_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (BRANCH_EN) begin
            fetch_pc_d = BRANCH_TARGET;
            issue_d    = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue_ok) begin
                tag_d      = fetch_pc_q;
                issue_d    = 1'b1;
                fetch_pc_d = fetch_pc_q + 1'b1;
            end else begin
                issue_d    = 1'b0;
            end
            if (push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            tag_q      <= '0;
            issue_q    <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_q      <= tag_d;
            issue_q    <= issue_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= IMEM_DATA;
            pc_q[wr_ptr_q]   <= tag_q;
        end
    end

    assign IMEM_ADDR   = fetch_pc_q;
    assign INSTR_VALID = valid;
    assign INSTR       = valid ? data_q[rd_ptr_q] : '0;
    assign INSTR_PC    = valid ? pc_q[rd_ptr_q]   : '0;

`ifdef IFU_BUBBLE_CNT_EN
    logic [31:0] bubbles_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bubbles_q <= '0;
        end else if (INSTR_READY & ~valid & (bubbles_q != '1)) begin
            bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign PERF_BUBBLES = bubbles_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed table, reset and wrap
// sequences, then random traffic against a queue-based reference model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_en;
    logic [31:0] branch_target;

    logic [7:0]  imem_addr8;
    logic [31:0] imem_data8;
    logic [31:0] instr8;
    logic [7:0]  instr_pc8;
    logic        instr_valid8;
    logic        ready8;
    logic        br8;
    logic [7:0]  tgt8;

`ifdef IFU_BUBBLE_CNT_EN
    logic [31:0] perf;
    logic [31:0] perf8;
`endif

    int npass;
    int ntotal;

    instruction_fetch_unit dut (
        .CLK          (clk),
        .RST          (rst),
        .IMEM_ADDR    (imem_addr),
        .IMEM_DATA    (imem_data),
        .INSTR        (instr),
        .INSTR_PC     (instr_pc),
        .INSTR_VALID  (instr_valid),
        .INSTR_READY  (instr_ready),
`ifdef IFU_BUBBLE_CNT_EN
        .PERF_BUBBLES (perf),
`endif
        .BRANCH_EN    (branch_en),
        .BRANCH_TARGET(branch_target)
    );

    instruction_fetch_unit #(
        .ADDR_W  (8),
        .DATA_W  (32),
        .RESET_PC(8'hFE)
    ) dut8 (
        .CLK          (clk),
        .RST          (rst),
        .IMEM_ADDR    (imem_addr8),
        .IMEM_DATA    (imem_data8),
        .INSTR        (instr8),
        .INSTR_PC     (instr_pc8),
        .INSTR_VALID  (instr_valid8),
        .INSTR_READY  (ready8),
`ifdef IFU_BUBBLE_CNT_EN
        .PERF_BUBBLES (perf8),
`endif
        .BRANCH_EN    (br8),
        .BRANCH_TARGET(tgt8)
    );

    // Instruction memory: mem[i] = i, one-cycle synchronous read
    always @(posedge clk) begin
        imem_data  <= imem_addr;
        imem_data8 <= {24'b0, imem_addr8};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: buffered PCs in a queue, one optional read in flight
    logic [31:0] mq[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fpc;
    logic [31:0] m_perf;

    task automatic model_reset();
        mq.delete();
        m_infl    = 0;
        m_infl_pc = 0;
        m_fpc     = 0;
        m_perf    = 0;
    endtask

    task automatic model_step(input bit rdy, input bit br, input logic [31:0] tgt);
        bit pop;
        int room;
        pop = (mq.size() > 0) && rdy;
        if (rdy && mq.size() == 0 && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        if (br) begin
            mq.delete();
            m_infl = 0;
            m_fpc  = tgt;
        end else begin
            room = mq.size() + int'(m_infl) - int'(pop);
            if (pop) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (room < 2) begin
                m_infl    = 1;
                m_infl_pc = m_fpc;
                m_fpc     = m_fpc + 1;
            end else begin
                m_infl = 0;
            end
        end
    endtask

    task automatic model_check(input int cyc);
        bit ev;
        ev = mq.size() > 0;
        chk($sformatf("rand_valid@%0d", cyc), {31'b0, instr_valid}, {31'b0, ev});
        chk($sformatf("rand_addr@%0d", cyc), imem_addr, m_fpc);
        if (ev) begin
            chk($sformatf("rand_pc@%0d", cyc), instr_pc, mq[0]);
            chk($sformatf("rand_instr@%0d", cyc), instr, mq[0]);
        end
`ifdef IFU_BUBBLE_CNT_EN
        chk($sformatf("rand_perf@%0d", cyc), perf, m_perf);
`endif
    endtask

    typedef struct {
        bit          ready;
        bit          br;
        logic [31:0] tgt;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[18];

    initial begin
        npass = 0;
        ntotal = 0;
        // Row i: expected state after i edges past reset, then inputs for the next edge
        tbl[0]  = '{1, 0, 32'h0,  0, 32'h0,  32'h0};
        tbl[1]  = '{1, 0, 32'h0,  0, 32'h0,  32'h1};
        tbl[2]  = '{1, 0, 32'h0,  1, 32'h0,  32'h2};
        tbl[3]  = '{1, 0, 32'h0,  1, 32'h1,  32'h3};
        tbl[4]  = '{1, 0, 32'h0,  1, 32'h2,  32'h4};
        tbl[5]  = '{0, 0, 32'h0,  1, 32'h3,  32'h5};
        tbl[6]  = '{0, 0, 32'h0,  1, 32'h3,  32'h5};
        tbl[7]  = '{0, 0, 32'h0,  1, 32'h3,  32'h5};
        tbl[8]  = '{0, 0, 32'h0,  1, 32'h3,  32'h5};
        tbl[9]  = '{0, 0, 32'h0,  1, 32'h3,  32'h5};
        tbl[10] = '{1, 0, 32'h0,  1, 32'h3,  32'h5};
        tbl[11] = '{1, 0, 32'h0,  1, 32'h4,  32'h6};
        tbl[12] = '{1, 0, 32'h0,  1, 32'h5,  32'h7};
        tbl[13] = '{1, 1, 32'h40, 1, 32'h6,  32'h8};
        tbl[14] = '{1, 0, 32'h0,  0, 32'h0,  32'h40};
        tbl[15] = '{1, 0, 32'h0,  0, 32'h0,  32'h41};
        tbl[16] = '{1, 0, 32'h0,  1, 32'h40, 32'h42};
        tbl[17] = '{1, 0, 32'h0,  1, 32'h41, 32'h43};

        rst = 1'b1;
        instr_ready = 1'b0;
        branch_en = 1'b0;
        branch_target = '0;
        ready8 = 1'b1;
        br8 = 1'b0;
        tgt8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset_instr", instr, 32'h0);
        chk("reset_pc", instr_pc, 32'h0);

        for (int i = 0; i < 18; i++) begin
            chk($sformatf("tbl_valid[%0d]", i), {31'b0, instr_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("tbl_addr[%0d]", i), imem_addr, tbl[i].eaddr);
            if (tbl[i].ev) begin
                chk($sformatf("tbl_pc[%0d]", i), instr_pc, tbl[i].epc);
                chk($sformatf("tbl_instr[%0d]", i), instr, tbl[i].epc);
            end
            if (i >= 2 && i <= 5) begin
                logic [7:0] e8;
                e8 = 8'hFE + 8'(i - 2);
                chk($sformatf("wrap_valid[%0d]", i), {31'b0, instr_valid8}, 32'h1);
                chk($sformatf("wrap_pc[%0d]", i), {24'b0, instr_pc8}, {24'b0, e8});
                chk($sformatf("wrap_instr[%0d]", i), instr8, {24'b0, e8});
            end
`ifdef IFU_BUBBLE_CNT_EN
            if (i == 10) chk("perf_after_reset", perf, 32'd2);
            if (i == 16) chk("perf_after_branch", perf, 32'd4);
`endif
            instr_ready   = tbl[i].ready;
            branch_en     = tbl[i].br;
            branch_target = tbl[i].tgt;
            @(negedge clk);
        end

        // Asynchronous reset while a word is presented
        instr_ready = 1'b1;
        branch_en = 1'b0;
        chk("mid_valid_before", {31'b0, instr_valid}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_instr", instr, 32'h0);
`ifdef IFU_BUBBLE_CNT_EN
        chk("mid_rst_perf", perf, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            bit          r;
            bit          b;
            logic [31:0] t;
            model_check(c);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
            end
            r = $urandom_range(0, 9) < 7;
            b = $urandom_range(0, 15) == 0;
            t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            instr_ready   = r;
            branch_en     = b;
            branch_target = t;
            if (rst) model_reset();
            else model_step(r, b, t);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
